pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It produces the 6-bit `stall` vector consumed by the pc_reg, if_id, id_ex, ex_mem and mem_wb registers, and it owns the cycle counter for multi-cycle EX operations (mult/div). It also steers the exception/redirect flush. Each pipeline register holds when its own stall bit is 1; it inserts a bubble downstream when its bit is 1 and the next bit is 0.

---
 rtl/pipeline_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the 5-stage pipeline.
// Produces the per-stage stall vector, sequences multi-cycle EX ops
// (mult/div) and steers exception/redirect flushes.
// Optional feature macro: PIPE_FLUSH_EN (flush/redirect logic). When it is
// undefined, flush_req_i/flush_pc_i are ignored and flush_o/new_pc_o are 0.
module pipeline_ctrl #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id_i,
  input  logic                mc_start_i,
  input  logic [MC_CNT_W-1:0] mc_cycles_i,
  input  logic                stallreq_mem_i,
  input  logic                flush_req_i,
  input  logic [31:0]         flush_pc_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic [31:0]         new_pc_o,
  output logic                mc_done_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [MC_CNT_W-1:0] r_cnt;
  logic                r_mc_done;
  logic                r_busy;

  logic                w_flush;
  logic [31:0]         w_new_pc;
  logic                w_start_ok;
  logic                w_ex_stall;

`ifdef PIPE_FLUSH_EN
  assign w_flush  = flush_req_i;
  assign w_new_pc = flush_req_i ? flush_pc_i : '0;
`else
  logic w_unused_flush;
  assign w_unused_flush = ^{flush_req_i, flush_pc_i};
  assign w_flush  = 1'b0;
  assign w_new_pc = '0;
`endif

  // A start is taken only outside BUSY, with a nonzero length, and when no
  // flush is dropping it in the same cycle.
  assign w_start_ok = mc_start_i && (mc_cycles_i != '0) &&
                      (r_state != BUSY) && !w_flush;
  assign w_ex_stall = w_start_ok || (r_state == BUSY);

  // Stall vector, highest priority first: flush, MEM wait, EX multi-cycle, ID hazard.
  always_comb begin
    stall_o = '0;
    if (w_flush)
      stall_o = '0;
    else if (stallreq_mem_i)
      stall_o = 6'b011111;
    else if (w_ex_stall)
      stall_o = 6'b001111;
    else if (stallreq_id_i)
      stall_o = 6'b000111;
  end

  // Multi-cycle FSM with counter; done/busy flags registered alongside state.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mc_done <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        BUSY: begin
          // The functional unit keeps counting through MEM freezes.
          r_cnt <= r_cnt - MC_CNT_W'(1);
          if (r_cnt == MC_CNT_W'(1)) begin
            r_state   <= DONE;
            r_mc_done <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          if (w_start_ok) begin
            r_cnt <= mc_cycles_i - MC_CNT_W'(1);
            if (mc_cycles_i == MC_CNT_W'(1)) begin
              r_state   <= DONE;
              r_mc_done <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_state   <= BUSY;
              r_mc_done <= 1'b0;
              r_busy    <= 1'b1;
            end
          end else if ((r_state == DONE) && stallreq_mem_i) begin
            // Result stays valid while MEM holds the pipeline.
            r_state   <= DONE;
            r_mc_done <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_state   <= IDLE;
            r_mc_done <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign flush_o   = w_flush;
  assign new_pc_o  = w_new_pc;
  assign mc_done_o = r_mc_done;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled mid-cycle (posedge + 5).
module tb_pipeline_ctrl;

  localparam int MC_CNT_W = 6;
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;
  localparam logic [5:0] S_MEM  = 6'b011111;

  logic                clk = 1'b0;
  logic                rst;
  logic                stallreq_id_i;
  logic                mc_start_i;
  logic [MC_CNT_W-1:0] mc_cycles_i;
  logic                stallreq_mem_i;
  logic                flush_req_i;
  logic [31:0]         flush_pc_i;
  logic [5:0]          stall_o;
  logic                flush_o;
  logic [31:0]         new_pc_o;
  logic                mc_done_o;
  logic                busy_o;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_ctrl #(.MC_CNT_W(MC_CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .mc_start_i     (mc_start_i),
    .mc_cycles_i    (mc_cycles_i),
    .stallreq_mem_i (stallreq_mem_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .mc_done_o      (mc_done_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    rst            = 1'b0;
    stallreq_id_i  = 1'b0;
    mc_start_i     = 1'b0;
    mc_cycles_i    = '0;
    stallreq_mem_i = 1'b0;
    flush_req_i    = 1'b0;
    flush_pc_i     = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      n_checks++;
      if (stall_o !== S_NONE) begin
        n_errors++; $display("FAIL reset_stall[%0d]: got %b want %b", i, stall_o, S_NONE);
      end
      n_checks++;
      if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin
        n_errors++; $display("FAIL reset_flush[%0d]: got %b/%h want 0/0", i, flush_o, new_pc_o);
      end
      n_checks++;
      if (mc_done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_errors++; $display("FAIL reset_done_busy[%0d]: got %b/%b want 0/0", i, mc_done_o, busy_o);
      end
      next_cycle();
    end
  endtask

  task automatic test_id_stall();
    logic [5:0] es [3] = '{S_ID, S_NONE, S_MEM};
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      stallreq_id_i  = (i == 0) || (i == 2);
      stallreq_mem_i = (i == 2);
      #4;
      n_checks++;
      if (stall_o !== es[i]) begin
        n_errors++; $display("FAIL id_stall[%0d]: got %b want %b", i, stall_o, es[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // N=3 with an ID hazard riding along: EX wins at t+1, ID shows in the done cycle.
  task automatic test_mc_n3();
    logic [5:0] es [5] = '{S_EX, S_EX, S_EX, S_ID, S_NONE};
    logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      mc_start_i    = (i == 0);
      mc_cycles_i   = (i == 0) ? 6'd3 : 6'd0;
      stallreq_id_i = (i == 1) || (i == 3);
      #4;
      n_checks++;
      if (stall_o !== es[i] || mc_done_o !== ed[i] || busy_o !== eb[i]) begin
        n_errors++;
        $display("FAIL mc_n3[%0d]: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                 i, stall_o, mc_done_o, busy_o, es[i], ed[i], eb[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_mc_n1_n0();
    // cycles 0..2: N=1 at 0; cycles 3..5: N=0 at 3 (ignored)
    logic [5:0] es [6] = '{S_EX, S_NONE, S_NONE, S_NONE, S_NONE, S_NONE};
    logic       ed [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       eb [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      mc_start_i  = (i == 0) || (i == 3);
      mc_cycles_i = (i == 0) ? 6'd1 : 6'd0;
      #4;
      n_checks++;
      if (stall_o !== es[i] || mc_done_o !== ed[i] || busy_o !== eb[i]) begin
        n_errors++;
        $display("FAIL mc_n1_n0[%0d]: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                 i, stall_o, mc_done_o, busy_o, es[i], ed[i], eb[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // N=4 at t, MEM wait over t+2..t+5: done held t+4..t+6, gone at t+7.
  task automatic test_mem_hold();
    logic [5:0] es [8] = '{S_EX, S_EX, S_MEM, S_MEM, S_MEM, S_MEM, S_NONE, S_NONE};
    logic       ed [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eb [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      mc_start_i     = (i == 0);
      mc_cycles_i    = (i == 0) ? 6'd4 : 6'd0;
      stallreq_mem_i = (i >= 2) && (i <= 5);
      #4;
      n_checks++;
      if (stall_o !== es[i] || mc_done_o !== ed[i] || busy_o !== eb[i]) begin
        n_errors++;
        $display("FAIL mem_hold[%0d]: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                 i, stall_o, mc_done_o, busy_o, es[i], ed[i], eb[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    // N=2 at 0, second N=2 in the DONE cycle (2)
    logic [5:0] es [6] = '{S_EX, S_EX, S_EX, S_EX, S_NONE, S_NONE};
    logic       ed [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       eb [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      mc_start_i  = (i == 0) || (i == 2);
      mc_cycles_i = (i == 0 || i == 2) ? 6'd2 : 6'd0;
      #4;
      n_checks++;
      if (stall_o !== es[i] || mc_done_o !== ed[i] || busy_o !== eb[i]) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                 i, stall_o, mc_done_o, busy_o, es[i], ed[i], eb[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_start_busy();
    // N=3 at 0, a stray N=1 start at 1 must not shorten the op
    logic [5:0] es [5] = '{S_EX, S_EX, S_EX, S_NONE, S_NONE};
    logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      mc_start_i  = (i == 0) || (i == 1);
      mc_cycles_i = (i == 0) ? 6'd3 : ((i == 1) ? 6'd1 : 6'd0);
      #4;
      n_checks++;
      if (stall_o !== es[i] || mc_done_o !== ed[i]) begin
        n_errors++;
        $display("FAIL start_busy[%0d]: got stall=%b done=%b want stall=%b done=%b",
                 i, stall_o, mc_done_o, es[i], ed[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // N=5 at t, flush request at t+2 with target 0x180.
  task automatic test_flush();
`ifdef PIPE_FLUSH_EN
    logic [5:0]  es [7] = '{S_EX, S_EX, S_NONE, S_NONE, S_NONE, S_NONE, S_NONE};
    logic        ef [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ep [7] = '{32'h0, 32'h0, 32'h180, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        eb [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic [5:0]  es [7] = '{S_EX, S_EX, S_EX, S_EX, S_EX, S_NONE, S_NONE};
    logic        ef [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ep [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        eb [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      mc_start_i  = (i == 0);
      mc_cycles_i = (i == 0) ? 6'd5 : 6'd0;
      flush_req_i = (i == 2);
      flush_pc_i  = (i == 2) ? 32'h0000_0180 : 32'h0;
      #4;
      n_checks++;
      if (stall_o !== es[i] || flush_o !== ef[i] || new_pc_o !== ep[i] ||
          mc_done_o !== ed[i] || busy_o !== eb[i]) begin
        n_errors++;
        $display("FAIL flush[%0d]: got stall=%b flush=%b pc=%h done=%b busy=%b want stall=%b flush=%b pc=%h done=%b busy=%b",
                 i, stall_o, flush_o, new_pc_o, mc_done_o, busy_o, es[i], ef[i], ep[i], ed[i], eb[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Flush coinciding with a start (N=2, target 0x200).
  task automatic test_flush_start();
`ifdef PIPE_FLUSH_EN
    logic [5:0] es [4] = '{S_NONE, S_NONE, S_NONE, S_NONE};
    logic       ef [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       ed [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       eb [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic [5:0] es [4] = '{S_EX, S_EX, S_NONE, S_NONE};
    logic       ef [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       ed [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      mc_start_i  = (i == 0);
      mc_cycles_i = (i == 0) ? 6'd2 : 6'd0;
      flush_req_i = (i == 0);
      flush_pc_i  = (i == 0) ? 32'h0000_0200 : 32'h0;
      #4;
      n_checks++;
      if (stall_o !== es[i] || flush_o !== ef[i] || mc_done_o !== ed[i] || busy_o !== eb[i]) begin
        n_errors++;
        $display("FAIL flush_start[%0d]: got stall=%b flush=%b done=%b busy=%b want stall=%b flush=%b done=%b busy=%b",
                 i, stall_o, flush_o, mc_done_o, busy_o, es[i], ef[i], ed[i], eb[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // N=5 at t, reset at t+1: idle from t+2, no done ever.
  task automatic test_reset_mid();
    logic [5:0] es [7] = '{S_EX, S_EX, S_NONE, S_NONE, S_NONE, S_NONE, S_NONE};
    logic       eb [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      mc_start_i  = (i == 0);
      mc_cycles_i = (i == 0) ? 6'd5 : 6'd0;
      rst         = (i == 1);
      #4;
      n_checks++;
      if (stall_o !== es[i] || mc_done_o !== 1'b0 || busy_o !== eb[i]) begin
        n_errors++;
        $display("FAIL reset_mid[%0d]: got stall=%b done=%b busy=%b want stall=%b done=0 busy=%b",
                 i, stall_o, mc_done_o, busy_o, es[i], eb[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    next_cycle();
    test_reset();
    test_id_stall();
    test_mc_n3();
    test_mc_n1_n0();
    test_mem_hold();
    test_back_to_back();
    test_start_busy();
    test_flush();
    test_flush_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
